// File: rtl/fifo_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// fifo_serial_tx_pkg : state encoding and helpers shared by the serial tx.
// Revision: 1.0
// ============================================================================
package fifo_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_START = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6
  } state_e;

  localparam int DATA_W_DEF = 4;
  localparam int FRAME_BITS = DATA_W_DEF + 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// serial_bit_timer : bit-period timer, counts 0..CLKS_PER_BIT-1 and ticks on
// the last cycle of each bit. Revision: 1.0
// ============================================================================
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// fifo_serial_tx : pops words from a registered FIFO and sends each one as an
// LSB-first start/data/stop serial frame. Revision: 1.0
// ============================================================================
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int RD_PULSE     = 2,
  parameter int RD_LAT       = 3,
  parameter int RST_HOLD     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_CNT = max_int(max_int(RD_PULSE, RD_LAT), RST_HOLD);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(DATA_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               w_tick;
  logic               w_timer_en;

  assign w_timer_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);

  serial_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (!w_timer_en),
    .en_i   (w_timer_en),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    fifo_read  = 1'b0;
    tx         = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      // The FIFO's empty flag is unreliable right after its reset; wait it out.
      ST_HOLD: begin
        busy = 1'b0;
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        fifo_read = 1'b1;
        if (cnt_q == CNT_W'(RD_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          cnt_d   = '0;
          shift_d = fifo_data;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (w_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (w_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        frame_done = w_tick;
        if (w_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_HOLD;
      end
    endcase
  end

endmodule
`default_nettype wire
